// File: rtl/tx_block_serializer.sv
// Serialises 66-bit sync+payload blocks onto a one-bit lane feeding the scrambler,
// gating scrambler advance to payload bits and aligning reseed pulses to block starts.
module tx_block_serializer #(
    parameter int DATA_W = 64,
    parameter int SYNC_W = 2,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [SYNC_W-1:0] blk_sync,
    input  logic [DATA_W-1:0] blk_data,
    input  logic              scr_rst_req,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_scr_en,
    output logic              ser_bypass,
    output logic              scr_rst,
    output logic              blk_start,
    output logic              hdr_err,
    output logic              underrun
);

    localparam int BLK_W = SYNC_W + DATA_W;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [BLK_W-1:0]   shreg, shreg_n;
    logic               pend, pend_n;
    logic               last_bit;
    logic               accept;
    logic               hdr_ok;
    logic               valid_n, bypass_n, scr_en_n, start_n, srst_n, herr_n, udr_n;

    assign last_bit  = (state == DATA) && (bit_cnt == DATA_LAST);
    assign blk_ready = (state == IDLE) || last_bit;
    assign accept    = blk_valid && blk_ready;
    assign hdr_ok    = (blk_sync == SYNC_W'(1)) || (blk_sync == SYNC_W'(2));

    // The bit on the lane is always bit 0 of the shift register, so ser_data is a flop output.
    assign ser_data = shreg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            pend       <= 1'b0;
            ser_valid  <= 1'b0;
            ser_bypass <= 1'b0;
            ser_scr_en <= 1'b0;
            blk_start  <= 1'b0;
            scr_rst    <= 1'b0;
            hdr_err    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            pend       <= pend_n;
            ser_valid  <= valid_n;
            ser_bypass <= bypass_n;
            ser_scr_en <= scr_en_n;
            blk_start  <= start_n;
            scr_rst    <= srst_n;
            hdr_err    <= herr_n;
            underrun   <= udr_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg >> 1;
        case (state)
            IDLE: begin
                shreg_n = '0;
                if (accept) begin
                    state_n   = SYNC;
                    bit_cnt_n = '0;
                    shreg_n   = {blk_data, blk_sync};
                end
            end
            SYNC: begin
                if (bit_cnt == SYNC_LAST) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_bit) begin
                    bit_cnt_n = '0;
                    if (accept) begin
                        state_n = SYNC;
                        shreg_n = {blk_data, blk_sync};
                    end else begin
                        state_n = IDLE;
                        shreg_n = '0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                shreg_n   = '0;
            end
        endcase
    end

    // Output flags are decoded from the next state so they leave on flops aligned with shreg[0].
    always_comb begin
        valid_n  = (state_n != IDLE);
        bypass_n = (state_n == SYNC);
        scr_en_n = (state_n == DATA);
        start_n  = accept;
        srst_n   = accept && (pend || scr_rst_req);
        herr_n   = accept && !hdr_ok;
        udr_n    = last_bit && !accept;
        pend_n   = accept ? 1'b0 : (pend || scr_rst_req);
    end

endmodule
